// File: rtl/axi_protocol_checker.sv
// Passive AXI protocol monitor for the AW, W, B, AR and R channels: handshake timeouts, payload
// stability, valid drops, outstanding-burst tracking, sticky flags and a saturating violation count.

module axi_chan_mon #(
    parameter int PW       = 8,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    input  logic          ready,
    input  logic [PW-1:0] payload,
    output logic          timeout,
    output logic          unstable,
    output logic          drop
);
    localparam int             WW       = $clog2(MAX_WAIT + 2);
    localparam logic [WW-1:0]  WAIT_LIM = WW'(MAX_WAIT);

    logic          stall_s;
    logic          stall_r;
    logic [PW-1:0] held_r;
    logic [WW-1:0] wait_r;
    logic [WW-1:0] wait_nxt_s;

    assign stall_s = valid & ~ready;

    // Count stalled cycles; park one past the limit so a long stall reports only once
    always_comb begin
        wait_nxt_s = {WW{1'b0}};
        if (stall_s) begin
            if (wait_r <= WAIT_LIM) begin
                wait_nxt_s = wait_r + WW'(1);
            end else begin
                wait_nxt_s = wait_r;
            end
        end else begin
            wait_nxt_s = {WW{1'b0}};
        end
    end

    // Stall bit, wait counter and the payload captured while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= 1'b0;
            wait_r  <= {WW{1'b0}};
            held_r  <= {PW{1'b0}};
        end else begin
            stall_r <= stall_s;
            wait_r  <= wait_nxt_s;
            if (stall_s) begin
                held_r <= payload;
            end else begin
                held_r <= held_r;
            end
        end
    end

    assign timeout  = stall_s && (wait_r == WAIT_LIM);
    assign unstable = stall_r && valid && (payload != held_r);
    assign drop     = stall_r && !valid;
endmodule

module axi_protocol_checker #(
    parameter int MAX_WAIT = 3,
    parameter int MAX_OUT  = 8,
    parameter int AW_PW    = 48,
    parameter int W_PW     = 37,
    parameter int B_PW     = 6,
    parameter int AR_PW    = 48,
    parameter int R_PW     = 39,
    parameter int CNT_W    = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           clear,
    input  logic                           awvalid,
    input  logic                           awready,
    input  logic [AW_PW-1:0]               aw_payload,
    input  logic                           wvalid,
    input  logic                           wready,
    input  logic [W_PW-1:0]                w_payload,
    input  logic                           bvalid,
    input  logic                           bready,
    input  logic [B_PW-1:0]                b_payload,
    input  logic                           arvalid,
    input  logic                           arready,
    input  logic [AR_PW-1:0]               ar_payload,
    input  logic                           rvalid,
    input  logic                           rready,
    input  logic [R_PW-1:0]                r_payload,
    input  logic                           rlast,
    output logic [18:0]                    err_flags,
    output logic                           err_pulse,
    output logic [CNT_W-1:0]               err_count,
    output logic [$clog2(MAX_OUT+1)-1:0]   wr_outstanding,
    output logic [$clog2(MAX_OUT+1)-1:0]   rd_outstanding
);
    localparam int             OW        = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0]  OUT_LIM   = OW'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [4:0]       to_s;
    logic [4:0]       unst_s;
    logic [4:0]       drop_s;
    logic             aw_hs_s, b_hs_s, ar_hs_s, r_done_s;
    logic             wr_under_s, wr_over_s, rd_under_s, rd_over_s;
    logic [OW-1:0]    wr_nxt_s, rd_nxt_s;
    logic [18:0]      viol_s;
    logic [18:0]      flags_nxt_s;
    logic [CNT_W-1:0] cnt_base_s, cnt_nxt_s;
    logic [18:0]      flags_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;
    logic [OW-1:0]    wr_r, rd_r;

    axi_chan_mon #(.PW(AW_PW), .MAX_WAIT(MAX_WAIT)) u_aw (
        .clk(aclk), .rst_n(aresetn), .valid(awvalid), .ready(awready), .payload(aw_payload),
        .timeout(to_s[0]), .unstable(unst_s[0]), .drop(drop_s[0]));
    axi_chan_mon #(.PW(W_PW), .MAX_WAIT(MAX_WAIT)) u_w (
        .clk(aclk), .rst_n(aresetn), .valid(wvalid), .ready(wready), .payload(w_payload),
        .timeout(to_s[1]), .unstable(unst_s[1]), .drop(drop_s[1]));
    axi_chan_mon #(.PW(B_PW), .MAX_WAIT(MAX_WAIT)) u_b (
        .clk(aclk), .rst_n(aresetn), .valid(bvalid), .ready(bready), .payload(b_payload),
        .timeout(to_s[2]), .unstable(unst_s[2]), .drop(drop_s[2]));
    axi_chan_mon #(.PW(AR_PW), .MAX_WAIT(MAX_WAIT)) u_ar (
        .clk(aclk), .rst_n(aresetn), .valid(arvalid), .ready(arready), .payload(ar_payload),
        .timeout(to_s[3]), .unstable(unst_s[3]), .drop(drop_s[3]));
    axi_chan_mon #(.PW(R_PW), .MAX_WAIT(MAX_WAIT)) u_r (
        .clk(aclk), .rst_n(aresetn), .valid(rvalid), .ready(rready), .payload(r_payload),
        .timeout(to_s[4]), .unstable(unst_s[4]), .drop(drop_s[4]));

    assign aw_hs_s  = awvalid & awready;
    assign b_hs_s   = bvalid & bready;
    assign ar_hs_s  = arvalid & arready;
    assign r_done_s = rvalid & rready & rlast;

    // Write bursts: opened by AW, closed by B; a simultaneous open and close cancels out
    always_comb begin
        wr_nxt_s   = wr_r;
        wr_under_s = 1'b0;
        wr_over_s  = 1'b0;
        if (aw_hs_s && !b_hs_s) begin
            if (wr_r == OUT_LIM) begin
                wr_over_s = 1'b1;
            end else begin
                wr_nxt_s = wr_r + OW'(1);
            end
        end else if (b_hs_s && !aw_hs_s) begin
            if (wr_r == {OW{1'b0}}) begin
                wr_under_s = 1'b1;
            end else begin
                wr_nxt_s = wr_r - OW'(1);
            end
        end else begin
            wr_nxt_s = wr_r;
        end
    end

    // Read bursts: opened by AR, closed only by the last R beat
    always_comb begin
        rd_nxt_s   = rd_r;
        rd_under_s = 1'b0;
        rd_over_s  = 1'b0;
        if (ar_hs_s && !r_done_s) begin
            if (rd_r == OUT_LIM) begin
                rd_over_s = 1'b1;
            end else begin
                rd_nxt_s = rd_r + OW'(1);
            end
        end else if (r_done_s && !ar_hs_s) begin
            if (rd_r == {OW{1'b0}}) begin
                rd_under_s = 1'b1;
            end else begin
                rd_nxt_s = rd_r - OW'(1);
            end
        end else begin
            rd_nxt_s = rd_r;
        end
    end

    assign viol_s = {rd_over_s, rd_under_s, wr_over_s, wr_under_s,
                     drop_s[4], unst_s[4], to_s[4],
                     drop_s[3], unst_s[3], to_s[3],
                     drop_s[2], unst_s[2], to_s[2],
                     drop_s[1], unst_s[1], to_s[1],
                     drop_s[0], unst_s[0], to_s[0]};

    // Clear wipes history first so a violation in the same cycle still lands
    always_comb begin
        flags_nxt_s = flags_r | viol_s;
        cnt_base_s  = cnt_r;
        if (clear) begin
            flags_nxt_s = viol_s;
            cnt_base_s  = {CNT_W{1'b0}};
        end else begin
            flags_nxt_s = flags_r | viol_s;
            cnt_base_s  = cnt_r;
        end
        if ((|viol_s) && (cnt_base_s != CNT_MAX)) begin
            cnt_nxt_s = cnt_base_s + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_base_s;
        end
    end

    // Status and outstanding-burst registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            flags_r <= 19'd0;
            pulse_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            wr_r    <= {OW{1'b0}};
            rd_r    <= {OW{1'b0}};
        end else begin
            flags_r <= flags_nxt_s;
            pulse_r <= |viol_s;
            cnt_r   <= cnt_nxt_s;
            wr_r    <= wr_nxt_s;
            rd_r    <= rd_nxt_s;
        end
    end

    assign err_flags      = flags_r;
    assign err_pulse      = pulse_r;
    assign err_count      = cnt_r;
    assign wr_outstanding = wr_r;
    assign rd_outstanding = rd_r;
endmodule

// File: tb/tb_axi_protocol_checker.sv
// Scoreboard bench for axi_protocol_checker: each scenario builds a plan of per-cycle stimulus with
// hand-derived expected status, pushes the expectation when driving and pops it after the edge.

module tb_axi_protocol_checker;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        clear = 1'b0;
    logic        awvalid = 1'b0, awready = 1'b0;
    logic [47:0] aw_payload = 48'd0;
    logic        wvalid = 1'b0, wready = 1'b0;
    logic [36:0] w_payload = 37'd0;
    logic        bvalid = 1'b0, bready = 1'b0;
    logic [5:0]  b_payload = 6'd0;
    logic        arvalid = 1'b0, arready = 1'b0;
    logic [47:0] ar_payload = 48'd0;
    logic        rvalid = 1'b0, rready = 1'b0;
    logic [38:0] r_payload = 39'd0;
    logic        rlast = 1'b0;
    logic [18:0] err_flags;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [3:0]  wr_outstanding;
    logic [3:0]  rd_outstanding;

    // stimulus word: {clear, awv, awr, wv, wr, bv, br, arv, arr, rv, rr, rlast}
    localparam logic [11:0] IDLE     = 12'h000;
    localparam logic [11:0] CLR      = 12'h800;
    localparam logic [11:0] AW_STALL = 12'h400;
    localparam logic [11:0] AW_HS    = 12'h600;
    localparam logic [11:0] W_STALL  = 12'h100;
    localparam logic [11:0] W_HS     = 12'h180;
    localparam logic [11:0] B_STALL  = 12'h040;
    localparam logic [11:0] B_HS     = 12'h060;
    localparam logic [11:0] AR_STALL = 12'h010;
    localparam logic [11:0] AR_HS    = 12'h018;
    localparam logic [11:0] R_BEAT   = 12'h006;
    localparam logic [11:0] R_LAST   = 12'h007;

    typedef struct {
        logic [11:0] s;
        logic [36:0] wp;
        logic [18:0] f;
        logic [7:0]  c;
        logic        p;
        logic [3:0]  w;
        logic [3:0]  r;
    } step_t;

    step_t plan[$];
    step_t sb[$];
    step_t e;
    int    tests_run = 0;
    int    tests_failed = 0;

    axi_protocol_checker dut (
        .aclk(aclk), .aresetn(aresetn), .clear(clear),
        .awvalid(awvalid), .awready(awready), .aw_payload(aw_payload),
        .wvalid(wvalid), .wready(wready), .w_payload(w_payload),
        .bvalid(bvalid), .bready(bready), .b_payload(b_payload),
        .arvalid(arvalid), .arready(arready), .ar_payload(ar_payload),
        .rvalid(rvalid), .rready(rready), .r_payload(r_payload), .rlast(rlast),
        .err_flags(err_flags), .err_pulse(err_pulse), .err_count(err_count),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding));

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [11:0] s, input logic [36:0] wp);
        {clear, awvalid, awready, wvalid, wready, bvalid, bready,
         arvalid, arready, rvalid, rready, rlast} = s;
        w_payload = wp;
    endtask

    task automatic add(input logic [11:0] s, input logic [36:0] wp, input logic [18:0] f,
                       input logic [7:0] c, input logic p, input logic [3:0] w, input logic [3:0] r);
        step_t st;
        st = '{s, wp, f, c, p, w, r};
        plan.push_back(st);
    endtask

    task automatic do_reset();
        drive(IDLE, 37'd0);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        plan.delete();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #1;
        tests_run++;
        if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== 36'd0) begin
            tests_failed++;
            $display("FAIL reset: flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d, expected all 0",
                     err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding);
        end
        do_reset();
    endtask

    task automatic test_aw_timeout();
        do_reset();
        repeat (3) add(AW_STALL, 37'd0, 19'h0, 8'd0, 1'b0, 4'd0, 4'd0);
        add(AW_STALL, 37'd0, 19'h1, 8'd1, 1'b1, 4'd0, 4'd0);
        add(AW_HS,    37'd0, 19'h1, 8'd1, 1'b0, 4'd1, 4'd0);
        add(IDLE,     37'd0, 19'h1, 8'd1, 1'b0, 4'd1, 4'd0);
        repeat (2) add(AW_STALL, 37'd0, 19'h1, 8'd1, 1'b0, 4'd1, 4'd0);
        add(AW_HS,    37'd0, 19'h1, 8'd1, 1'b0, 4'd2, 4'd0);
        add(IDLE,     37'd0, 19'h1, 8'd1, 1'b0, 4'd2, 4'd0);
        foreach (plan[i]) begin
            drive(plan[i].s, plan[i].wp);
            sb.push_back(plan[i]);
            tick();
            e = sb.pop_front();
            tests_run++;
            if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== {e.f, e.c, e.p, e.w, e.r}) begin
                tests_failed++;
                $display("FAIL aw_timeout step %0d: flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d, expected flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d",
                         i, err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding, e.f, e.c, e.p, e.w, e.r);
            end
        end
    endtask

    task automatic test_w_stability();
        do_reset();
        add(W_STALL, 37'h0A, 19'h00, 8'd0, 1'b0, 4'd0, 4'd0);
        add(W_STALL, 37'h0B, 19'h10, 8'd1, 1'b1, 4'd0, 4'd0);
        add(W_HS,    37'h0B, 19'h10, 8'd1, 1'b0, 4'd0, 4'd0);
        add(W_HS,    37'h0C, 19'h10, 8'd1, 1'b0, 4'd0, 4'd0);
        add(IDLE,    37'h0C, 19'h10, 8'd1, 1'b0, 4'd0, 4'd0);
        foreach (plan[i]) begin
            drive(plan[i].s, plan[i].wp);
            sb.push_back(plan[i]);
            tick();
            e = sb.pop_front();
            tests_run++;
            if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== {e.f, e.c, e.p, e.w, e.r}) begin
                tests_failed++;
                $display("FAIL w_stability step %0d: flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d, expected flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d",
                         i, err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding, e.f, e.c, e.p, e.w, e.r);
            end
        end
    endtask

    task automatic test_outstanding();
        do_reset();
        for (int k = 1; k <= 8; k++) add(AW_HS, 37'd0, 19'h0, 8'd0, 1'b0, 4'(k), 4'd0);
        add(AW_HS, 37'd0, 19'h10000, 8'd1, 1'b1, 4'd8, 4'd0);
        for (int k = 7; k >= 0; k--) add(B_HS, 37'd0, 19'h10000, 8'd1, 1'b0, 4'(k), 4'd0);
        add(B_HS, 37'd0, 19'h18000, 8'd2, 1'b1, 4'd0, 4'd0);
        for (int k = 1; k <= 3; k++) add(AW_HS, 37'd0, 19'h18000, 8'd2, 1'b0, 4'(k), 4'd0);
        add(AW_HS | B_HS, 37'd0, 19'h18000, 8'd2, 1'b0, 4'd3, 4'd0);
        add(IDLE,         37'd0, 19'h18000, 8'd2, 1'b0, 4'd3, 4'd0);
        foreach (plan[i]) begin
            drive(plan[i].s, plan[i].wp);
            sb.push_back(plan[i]);
            tick();
            e = sb.pop_front();
            tests_run++;
            if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== {e.f, e.c, e.p, e.w, e.r}) begin
                tests_failed++;
                $display("FAIL outstanding step %0d: flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d, expected flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d",
                         i, err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding, e.f, e.c, e.p, e.w, e.r);
            end
        end
    endtask

    task automatic test_read_burst();
        do_reset();
        add(AR_STALL, 37'd0, 19'h0, 8'd0, 1'b0, 4'd0, 4'd0);
        add(IDLE,     37'd0, 19'h800, 8'd1, 1'b1, 4'd0, 4'd0);
        add(IDLE,     37'd0, 19'h800, 8'd1, 1'b0, 4'd0, 4'd0);
        add(CLR,      37'd0, 19'h0, 8'd0, 1'b0, 4'd0, 4'd0);
        add(AR_HS,    37'd0, 19'h0, 8'd0, 1'b0, 4'd0, 4'd1);
        repeat (3) add(R_BEAT, 37'd0, 19'h0, 8'd0, 1'b0, 4'd0, 4'd1);
        add(R_LAST,   37'd0, 19'h0, 8'd0, 1'b0, 4'd0, 4'd0);
        add(IDLE,     37'd0, 19'h0, 8'd0, 1'b0, 4'd0, 4'd0);
        add(R_LAST,   37'd0, 19'h20000, 8'd1, 1'b1, 4'd0, 4'd0);
        foreach (plan[i]) begin
            drive(plan[i].s, plan[i].wp);
            sb.push_back(plan[i]);
            tick();
            e = sb.pop_front();
            tests_run++;
            if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== {e.f, e.c, e.p, e.w, e.r}) begin
                tests_failed++;
                $display("FAIL drop_read step %0d: flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d, expected flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d",
                         i, err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding, e.f, e.c, e.p, e.w, e.r);
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        add(AW_HS,    37'd0, 19'h0,   8'd0, 1'b0, 4'd1, 4'd0);
        add(AR_STALL, 37'd0, 19'h0,   8'd0, 1'b0, 4'd1, 4'd0);
        add(IDLE,     37'd0, 19'h800, 8'd1, 1'b1, 4'd1, 4'd0);
        repeat (3) add(B_STALL, 37'd0, 19'h800, 8'd1, 1'b0, 4'd1, 4'd0);
        add(B_STALL | CLR, 37'd0, 19'h40, 8'd1, 1'b1, 4'd1, 4'd0);
        add(B_HS,     37'd0, 19'h40,  8'd1, 1'b0, 4'd0, 4'd0);
        add(CLR,      37'd0, 19'h0,   8'd0, 1'b0, 4'd0, 4'd0);
        add(IDLE,     37'd0, 19'h0,   8'd0, 1'b0, 4'd0, 4'd0);
        foreach (plan[i]) begin
            drive(plan[i].s, plan[i].wp);
            sb.push_back(plan[i]);
            tick();
            e = sb.pop_front();
            tests_run++;
            if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== {e.f, e.c, e.p, e.w, e.r}) begin
                tests_failed++;
                $display("FAIL clear step %0d: flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d, expected flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d",
                         i, err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding, e.f, e.c, e.p, e.w, e.r);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        add(AR_STALL, 37'd0, 19'h0,   8'd0, 1'b0, 4'd0, 4'd0);
        add(IDLE,     37'd0, 19'h800, 8'd1, 1'b1, 4'd0, 4'd0);
        repeat (2) add(AW_STALL, 37'd0, 19'h800, 8'd1, 1'b0, 4'd0, 4'd0);
        repeat (3) add(AW_STALL, 37'd0, 19'h0, 8'd0, 1'b0, 4'd0, 4'd0);
        add(AW_STALL, 37'd0, 19'h1, 8'd1, 1'b1, 4'd0, 4'd0);
        add(AW_HS,    37'd0, 19'h1, 8'd1, 1'b0, 4'd1, 4'd0);
        foreach (plan[i]) begin
            drive(plan[i].s, plan[i].wp);
            sb.push_back(plan[i]);
            tick();
            if (i == 3) begin
                // async reset mid-cycle while the AW stall is still asserted
                aresetn = 1'b0;
                #1;
                tests_run++;
                if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== 36'd0) begin
                    tests_failed++;
                    $display("FAIL reset_async: flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d, expected all 0",
                             err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding);
                end
                #2;
                aresetn = 1'b1;
                for (int k = 0; k < 2; k++) void'(sb.pop_front());
                continue;
            end
            if (i == 2) continue;
            e = sb.pop_front();
            tests_run++;
            if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== {e.f, e.c, e.p, e.w, e.r}) begin
                tests_failed++;
                $display("FAIL reset_mid_stall step %0d: flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d, expected flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d",
                         i, err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding, e.f, e.c, e.p, e.w, e.r);
            end
        end
    endtask

    task automatic test_saturate();
        logic [18:0] f;
        logic [7:0]  c;
        do_reset();
        add(W_STALL, 37'd0, 19'h0, 8'd0, 1'b0, 4'd0, 4'd0);
        for (int k = 2; k <= 301; k++) begin
            f = (k >= 4) ? 19'h18 : 19'h10;
            c = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
            add(W_STALL, 37'(k), f, c, 1'b1, 4'd0, 4'd0);
        end
        add(IDLE, 37'd0, 19'h38, 8'd255, 1'b1, 4'd0, 4'd0);
        add(IDLE, 37'd0, 19'h38, 8'd255, 1'b0, 4'd0, 4'd0);
        foreach (plan[i]) begin
            drive(plan[i].s, plan[i].wp);
            sb.push_back(plan[i]);
            tick();
            e = sb.pop_front();
            tests_run++;
            if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== {e.f, e.c, e.p, e.w, e.r}) begin
                tests_failed++;
                $display("FAIL saturate step %0d: flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d, expected flags=%h cnt=%0d pulse=%b wr=%0d rd=%0d",
                         i, err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding, e.f, e.c, e.p, e.w, e.r);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_aw_timeout();
        test_w_stability();
        test_outstanding();
        test_read_burst();
        test_clear();
        test_reset_mid_stall();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/axi_protocol_checker.md
Name: axi_protocol_checker

Overview:
- Synthesizable, parametrised AXI handshake/protocol monitor covering all five channels (AW, W, B, AR, R).
- Passively observes the channel valid/ready/payload signals. Flags handshake timeouts, payload instability and valid drops, and tracks outstanding write and read transactions.
- Sticky error flags and a saturating error counter are exposed for the testbench scoreboard and for on-chip debug status.

Parameters:
- MAX_WAIT, 3: maximum cycles valid may stay high without ready (0 = ready required in the same cycle).
- MAX_OUT, 8: maximum outstanding write bursts and maximum outstanding read bursts (each counted separately).
- AW_PW, 48: AW payload width (addr+id+len+size+burst).
- W_PW, 37: W payload width (data+strb+last).
- B_PW, 6: B payload width (id+resp).
- AR_PW, 48: AR payload width.
- R_PW, 39: R payload width (data+id+resp+last).
- CNT_W, 8: error counter width.

Ports:
- aclk in 1: clock.
- aresetn in 1: asynchronous active-low reset.
- clear in 1: synchronous clear of err_flags and err_count.
- awvalid, awready in 1 each: AW handshake.
- aw_payload in AW_PW: AW payload.
- wvalid, wready in 1 each: W handshake.
- w_payload in W_PW: W payload.
- bvalid, bready in 1 each: B handshake.
- b_payload in B_PW: B payload.
- arvalid, arready in 1 each: AR handshake.
- ar_payload in AR_PW: AR payload.
- rvalid, rready in 1 each: R handshake.
- r_payload in R_PW: R payload.
- rlast in 1: R last beat.
- err_flags out 19: sticky error bits, map below.
- err_pulse out 1: high for one cycle after any new violation.
- err_count out CNT_W: saturating count of violation cycles.
- wr_outstanding out clog2(MAX_OUT+1): open write bursts.
- rd_outstanding out clog2(MAX_OUT+1): open read bursts.

Behaviour:
- Reset (aresetn=0, async): all outputs, wait counters, held payloads and prev-state registers are 0.
- Channel index c: AW=0, W=1, B=2, AR=3, R=4.
- err_flags map:
  - bit 3c: timeout.
  - bit 3c+1: unstable payload.
  - bit 3c+2: valid drop.
  - bit 15: write underflow. bit 16: write overflow.
  - bit 17: read underflow. bit 18: read overflow.
- Per-channel state: registered stall bit S = valid&&!ready from the previous cycle; held payload P; wait counter W, clog2(MAX_WAIT+2) bits.
- Wait counter:
  - W increments on each cycle with valid&&!ready.
  - W clears on ready or !valid.
  - Timeout is detected on the cycle where valid&&!ready and W==MAX_WAIT.
  - W then freezes at MAX_WAIT+1, so timeout reports once per stall.
- Unstable: S=1 && valid=1 && payload!=P.
- Valid drop: S=1 && valid=0.
- Latency: every violation is detected from sampled inputs at edge k. The flag bit, err_pulse and err_count update at edge k, so they are visible in cycle k+1.
- Outstanding write counter:
  - +1 on AW handshake, -1 on B handshake. Simultaneous AW and B handshakes leave it unchanged with no error.
  - B handshake with count 0 and no AW handshake: set bit 15, count stays 0.
  - AW handshake with count MAX_OUT and no B handshake: set bit 16, count stays MAX_OUT.
- Outstanding read counter: same rules with AR as increment and R handshake with rlast=1 as decrement; bits 17 and 18. R beats with rlast=0 are not counted.
- err_count: +1 per cycle with at least one violation (any number of bits); saturates at 2^CNT_W-1.
- clear:
  - Zeroes err_flags and err_count.
  - Outstanding counters and wait counters are untouched.
  - A violation in the same cycle as clear wins: its bit is set and err_count becomes 1.
- Flags are sticky until clear or reset. A repeated violation on an already-set bit still pulses err_pulse and increments err_count.
- Monitor only: no outputs drive the bus. There are no checks on ID ordering or burst length.

Test Plan:
- AW timeout: awvalid=1, awready=0 for 4 cycles, then awready=1 (MAX_WAIT=3) -> bit0 set one cycle after the 4th stall cycle, err_count=1, single err_pulse. Same pattern with awready at the 3rd cycle -> no error.
- W stability: wvalid=1, wready=0, w_payload changes 0x0A->0x0B on the next cycle -> bit4 set, err_count=1. A change after a handshake gives no error.
- Valid drop: arvalid 1->0 with arready=0 throughout -> bit11 set. err_flags=0x800 after one cycle.
- Outstanding:
  - 8 AW handshakes -> wr_outstanding=8. A 9th AW -> bit16 set, count stays 8.
  - 8 B handshakes -> 0. A B handshake at 0 -> bit15 set.
  - Simultaneous AW+B at count 3 -> stays 3, no error.
- Read burst: AR, then 4 R beats with rlast only on the 4th -> rd_outstanding 1 until the last beat, then 0, no errors.
- Clear/reset:
  - clear coincident with a B timeout -> only bit6 set, err_count=1.
  - aresetn low mid-stall -> all outputs 0 immediately. After release, the stall resumes counting from 0.
  - 300 violation cycles with CNT_W=8 -> err_count=255.
